// File: rtl/umi_regif_burst.sv
// UMI device-side register interface with burst support.
// Accepts one UMI request at a time and splits a burst of LEN+1 words into
// sequential register-port accesses. Read words are packed into one response.
module umi_regif_burst #(
    parameter int unsigned CW    = 32,
    parameter int unsigned AW    = 64,
    parameter int unsigned DW    = 256,
    parameter int unsigned RW    = 32,
    parameter int unsigned RDLAT = 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          udev_req_valid,
    input  logic [CW-1:0] udev_req_cmd,
    input  logic [AW-1:0] udev_req_dstaddr,
    input  logic [AW-1:0] udev_req_srcaddr,
    input  logic [DW-1:0] udev_req_data,
    output logic          udev_req_ready,
    output logic          udev_resp_valid,
    output logic [CW-1:0] udev_resp_cmd,
    output logic [AW-1:0] udev_resp_dstaddr,
    output logic [AW-1:0] udev_resp_srcaddr,
    output logic [DW-1:0] udev_resp_data,
    input  logic          udev_resp_ready,
    output logic [AW-1:0] reg_addr,
    output logic          reg_write,
    output logic          reg_read,
    output logic [RW-1:0] reg_wrdata,
    input  logic [RW-1:0] reg_rddata,
    output logic          err_unsup
);

    localparam int unsigned NW = DW / RW;                     // words per burst
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;   // word index width
    localparam int unsigned BS = $clog2(RW / 8);              // log2 bytes per word

    typedef enum logic [1:0] {StIdle, StAccess, StDrain, StResp} state_e;

    state_e                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic [CW-1:0]          cmd_q, cmd_d;
    logic [AW-1:0]          dst_q, dst_d;
    logic [AW-1:0]          src_q, src_d;
    logic [NW-1:0][RW-1:0]  wdata_q, wdata_d;
    logic [NW-1:0][RW-1:0]  rdata_q, rdata_d;
    logic [IW-1:0]          cnt_q, cnt_d;
    // Read-return tracking: valid bit and word index, delayed RDLAT cycles.
    logic [RDLAT-1:0]          pvld_q, pvld_d;
    logic [RDLAT-1:0][IW-1:0]  pidx_q, pidx_d;

    logic [4:0] op_q;
    logic       op_read, op_post, in_access, in_resp, req_ok, last_beat;

    assign op_q      = cmd_q[4:0];
    assign op_read   = (op_q == 5'h01);
    assign op_post   = (op_q == 5'h05);
    assign in_access = (state_q == StAccess);
    assign in_resp   = (state_q == StResp);
    assign last_beat = (cnt_q == cmd_q[8 +: IW]);

    // Supported: request opcode, SIZE matching the port width, burst that fits DW.
    assign req_ok = ((udev_req_cmd[4:0] == 5'h01) || (udev_req_cmd[4:0] == 5'h03) ||
                     (udev_req_cmd[4:0] == 5'h05)) &&
                    (udev_req_cmd[7:5] == 3'(BS)) &&
                    (udev_req_cmd[15:8] <= 8'(NW - 1));

    assign reg_read       = in_access && op_read;
    assign reg_write      = in_access && !op_read;
    assign reg_addr       = in_access ? (dst_q + (AW'(cnt_q) << BS)) : '0;
    assign reg_wrdata     = reg_write ? wdata_q[cnt_q] : '0;
    assign udev_req_ready = ready_q;
    assign err_unsup      = err_q;

    // Response fields are zero outside RESP and held from registers inside it.
    assign udev_resp_valid   = in_resp;
    assign udev_resp_cmd     = in_resp ? {cmd_q[CW-1:5], (op_read ? 5'h02 : 5'h04)} : '0;
    assign udev_resp_dstaddr = in_resp ? src_q : '0;
    assign udev_resp_srcaddr = in_resp ? dst_q : '0;
    assign udev_resp_data    = in_resp ? rdata_q : '0;

    // Next-state, request latching, beat counting and read-data capture.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        cmd_d   = cmd_q;
        dst_d   = dst_q;
        src_d   = src_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;

        pvld_d    = '0;
        pidx_d    = '0;
        pvld_d[0] = reg_read;
        pidx_d[0] = cnt_q;
        for (int i = 1; i < RDLAT; i++) begin
            pvld_d[i] = pvld_q[i-1];
            pidx_d[i] = pidx_q[i-1];
        end
        if (pvld_q[RDLAT-1]) begin
            rdata_d[pidx_q[RDLAT-1]] = reg_rddata;
        end

        unique case (state_q)
            StIdle: begin
                if (udev_req_valid && ready_q) begin
                    cmd_d   = udev_req_cmd;
                    dst_d   = udev_req_dstaddr;
                    src_d   = udev_req_srcaddr;
                    wdata_d = udev_req_data;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (req_ok) state_d = StAccess;
                    else        err_d   = 1'b1;
                end
            end
            StAccess: begin
                if (last_beat) begin
                    if (op_read)      state_d = StDrain;
                    else if (op_post) state_d = StIdle;
                    else              state_d = StResp;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            StDrain: begin
                // Leave once the final word returns; it is captured on this same edge.
                if (pvld_q[RDLAT-1] && (pidx_q[RDLAT-1] == cmd_q[8 +: IW])) state_d = StResp;
            end
            StResp: begin
                if (udev_resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StIdle);
    end

    // State and datapath registers; reset discards any in-flight burst.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            cmd_q   <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            pvld_q  <= '0;
            pidx_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            pvld_q  <= pvld_d;
            pidx_q  <= pidx_d;
        end
    end

endmodule

// File: tb/tb_umi_regif_burst.sv
// Directed bench for umi_regif_burst: RDLAT=1 instance (a) and RDLAT=3 instance (b).
module tb_umi_regif_burst;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  cmd = '0;
    logic [63:0]  dst = '0, src = '0;
    logic [255:0] data = '0;
    logic         valid_a = 1'b0, valid_b = 1'b0, resp_ready_a = 1'b1;
    logic         ready_a, resp_valid_a, wr_a, rd_a, err_a;
    logic         ready_b, resp_valid_b, wr_b, rd_b, err_b;
    logic [31:0]  resp_cmd_a, resp_cmd_b, wrdata_a, wrdata_b, rddata_a, rddata_b;
    logic [63:0]  resp_dst_a, resp_src_a, addr_a, resp_dst_b, resp_src_b, addr_b;
    logic [255:0] resp_data_a, resp_data_b;

    int total = 0;
    int bad = 0;
    int both_cnt = 0;
    int wr_cnt_a = 0;

    umi_regif_burst #(.CW(32), .AW(64), .DW(256), .RW(32), .RDLAT(1)) u_dut_a (
        .clk(clk), .nreset(nreset),
        .udev_req_valid(valid_a), .udev_req_cmd(cmd), .udev_req_dstaddr(dst),
        .udev_req_srcaddr(src), .udev_req_data(data), .udev_req_ready(ready_a),
        .udev_resp_valid(resp_valid_a), .udev_resp_cmd(resp_cmd_a),
        .udev_resp_dstaddr(resp_dst_a), .udev_resp_srcaddr(resp_src_a),
        .udev_resp_data(resp_data_a), .udev_resp_ready(resp_ready_a),
        .reg_addr(addr_a), .reg_write(wr_a), .reg_read(rd_a), .reg_wrdata(wrdata_a),
        .reg_rddata(rddata_a), .err_unsup(err_a)
    );

    umi_regif_burst #(.CW(32), .AW(64), .DW(256), .RW(32), .RDLAT(3)) u_dut_b (
        .clk(clk), .nreset(nreset),
        .udev_req_valid(valid_b), .udev_req_cmd(cmd), .udev_req_dstaddr(dst),
        .udev_req_srcaddr(src), .udev_req_data(data), .udev_req_ready(ready_b),
        .udev_resp_valid(resp_valid_b), .udev_resp_cmd(resp_cmd_b),
        .udev_resp_dstaddr(resp_dst_b), .udev_resp_srcaddr(resp_src_b),
        .udev_resp_data(resp_data_b), .udev_resp_ready(1'b1),
        .reg_addr(addr_b), .reg_write(wr_b), .reg_read(rd_b), .reg_wrdata(wrdata_b),
        .reg_rddata(rddata_b), .err_unsup(err_b)
    );

    // Register file model for a: RDLAT=1.
    logic [31:0] mem_a [0:1023];
    logic [31:0] pa0 = '0;
    always @(posedge clk) begin
        if (wr_a) mem_a[addr_a[11:2]] <= wrdata_a;
        pa0 <= rd_a ? mem_a[addr_a[11:2]] : 32'h0;
    end
    assign rddata_a = pa0;

    // Model for b: RDLAT=3, data is a fixed function of address.
    logic [31:0] pb0 = '0, pb1 = '0, pb2 = '0;
    always @(posedge clk) begin
        pb0 <= rd_b ? (32'hCA00_0000 | {8'h0, addr_b[23:0]}) : 32'h0;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign rddata_b = pb2;

    // Monitors: strobe exclusivity and write counting.
    always @(posedge clk) begin
        if ((wr_a && rd_a) || (wr_b && rd_b)) both_cnt <= both_cnt + 1;
        if (wr_a) wr_cnt_a <= wr_cnt_a + 1;
    end

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] sz,
                                       input logic [7:0] len);
        return {16'hA55A, len, sz, op};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick; tick;
        total++;
        if ({ready_a, resp_valid_a, wr_a, rd_a, err_a} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000",
                            {ready_a, resp_valid_a, wr_a, rd_a, err_a});
        end
        total++;
        if ({addr_a, resp_cmd_a, resp_dst_a} !== '0) begin
            bad++; $display("FAIL reset_fields: got %0h want 0", {addr_a, resp_cmd_a, resp_dst_a});
        end
        nreset = 1'b1;
        tick;
        total++;
        if ({ready_a, ready_b} !== 2'b11) begin
            bad++; $display("FAIL reset_ready: got %b want 11", {ready_a, ready_b});
        end
    endtask

    task automatic test_write;
        int w0;
        cmd = mk(5'h03, 3'd2, 8'd3); dst = 64'h100; src = 64'hABCD_0000;
        for (int i = 0; i < 8; i++) data[i*32 +: 32] = 32'h11 * (i + 1);
        w0 = wr_cnt_a;
        valid_a = 1'b1; tick; valid_a = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            total++;
            if ({wr_a, rd_a, ready_a, resp_valid_a} !== 4'b1000) begin
                bad++; $display("FAIL wr_ctrl c%0d: got %b want 1000", c,
                                {wr_a, rd_a, ready_a, resp_valid_a});
            end
            total++;
            if (addr_a !== 64'h100 + 64'(4 * (c - 1)) || wrdata_a !== 32'(32'h11 * c)) begin
                bad++; $display("FAIL wr_beat c%0d: got %0h/%0h want %0h/%0h", c, addr_a,
                                wrdata_a, 64'h100 + 64'(4 * (c - 1)), 32'h11 * c);
            end
            tick;
        end
        total++;
        if (resp_valid_a !== 1'b1 || resp_cmd_a !== mk(5'h04, 3'd2, 8'd3)) begin
            bad++; $display("FAIL wr_resp: got v=%b cmd=%0h want v=1 cmd=%0h", resp_valid_a,
                            resp_cmd_a, mk(5'h04, 3'd2, 8'd3));
        end
        total++;
        if (resp_dst_a !== 64'hABCD_0000 || resp_src_a !== 64'h100 || resp_data_a !== '0) begin
            bad++; $display("FAIL wr_resp_fields: got %0h/%0h/%0h want abcd0000/100/0",
                            resp_dst_a, resp_src_a, resp_data_a);
        end
        tick;
        total++;
        if ({resp_valid_a, ready_a} !== 2'b01 || wr_cnt_a - w0 !== 4) begin
            bad++; $display("FAIL wr_done: got %b n=%0d want 01 n=4", {resp_valid_a, ready_a},
                            wr_cnt_a - w0);
        end
    endtask

    task automatic test_read;
        cmd = mk(5'h01, 3'd2, 8'd3); dst = 64'h100; src = 64'h5000;
        valid_a = 1'b1; tick; valid_a = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            total++;
            if ({rd_a, wr_a} !== 2'b10 || addr_a !== 64'h100 + 64'(4 * (c - 1))) begin
                bad++; $display("FAIL rd_beat c%0d: got %b %0h want 10 %0h", c, {rd_a, wr_a},
                                addr_a, 64'h100 + 64'(4 * (c - 1)));
            end
            tick;
        end
        total++;
        if ({resp_valid_a, rd_a} !== 2'b00) begin
            bad++; $display("FAIL rd_early: got %b want 00", {resp_valid_a, rd_a});
        end
        tick;
        total++;
        if (resp_valid_a !== 1'b1 ||
            resp_data_a !== 256'h00000044_00000033_00000022_00000011) begin
            bad++; $display("FAIL rd_resp: got v=%b d=%0h want v=1 d=44000000330000002200000011",
                            resp_valid_a, resp_data_a);
        end
        total++;
        if (resp_cmd_a !== mk(5'h02, 3'd2, 8'd3) || resp_dst_a !== 64'h5000) begin
            bad++; $display("FAIL rd_resp_cmd: got %0h/%0h want %0h/5000", resp_cmd_a,
                            resp_dst_a, mk(5'h02, 3'd2, 8'd3));
        end
        tick;
    endtask

    task automatic test_rdlat3;
        cmd = mk(5'h01, 3'd2, 8'd0); dst = 64'h10; src = 64'h20;
        valid_b = 1'b1; tick; valid_b = 1'b0;
        total++;
        if (rd_b !== 1'b1 || addr_b !== 64'h10) begin
            bad++; $display("FAIL l3_strobe: got %b %0h want 1 10", rd_b, addr_b);
        end
        for (int c = 2; c <= 4; c++) begin
            tick;
            total++;
            if ({rd_b, resp_valid_b} !== 2'b00) begin
                bad++; $display("FAIL l3_wait c%0d: got %b want 00", c, {rd_b, resp_valid_b});
            end
        end
        tick;
        total++;
        if (resp_valid_b !== 1'b1 || resp_data_b !== 256'hCA00_0010) begin
            bad++; $display("FAIL l3_resp: got v=%b d=%0h want v=1 d=ca000010", resp_valid_b,
                            resp_data_b);
        end
        tick;
    endtask

    task automatic test_posted;
        int w0;
        cmd = mk(5'h05, 3'd2, 8'd7); dst = 64'h200; src = 64'h0;
        for (int i = 0; i < 8; i++) data[i*32 +: 32] = 32'h1000 + i;
        w0 = wr_cnt_a;
        valid_a = 1'b1; tick; valid_a = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            total++;
            if ({wr_a, rd_a, ready_a, resp_valid_a} !== 4'b1000 ||
                addr_a !== 64'h200 + 64'(4 * (c - 1)) || wrdata_a !== 32'(32'h1000 + c - 1)) begin
                bad++; $display("FAIL post_beat c%0d: got %b %0h %0h want 1000 %0h %0h", c,
                                {wr_a, rd_a, ready_a, resp_valid_a}, addr_a, wrdata_a,
                                64'h200 + 64'(4 * (c - 1)), 32'h1000 + c - 1);
            end
            tick;
        end
        total++;
        if ({wr_a, rd_a, ready_a, resp_valid_a} !== 4'b0010 || wr_cnt_a - w0 !== 8) begin
            bad++; $display("FAIL post_done: got %b n=%0d want 0010 n=8",
                            {wr_a, rd_a, ready_a, resp_valid_a}, wr_cnt_a - w0);
        end
    endtask

    task automatic test_unsup;
        logic [31:0] cmds [3];
        cmds[0] = mk(5'h03, 3'd3, 8'd0);
        cmds[1] = mk(5'h03, 3'd2, 8'd8);
        cmds[2] = mk(5'h07, 3'd2, 8'd0);
        for (int k = 0; k < 3; k++) begin
            cmd = cmds[k]; dst = 64'h600;
            valid_a = 1'b1; tick; valid_a = 1'b0;
            total++;
            if ({err_a, wr_a, rd_a, ready_a, resp_valid_a} !== 5'b10010) begin
                bad++; $display("FAIL unsup_pulse k%0d: got %b want 10010", k,
                                {err_a, wr_a, rd_a, ready_a, resp_valid_a});
            end
            tick;
            total++;
            if ({err_a, wr_a, rd_a, ready_a, resp_valid_a} !== 5'b00010) begin
                bad++; $display("FAIL unsup_after k%0d: got %b want 00010", k,
                                {err_a, wr_a, rd_a, ready_a, resp_valid_a});
            end
        end
    endtask

    task automatic test_backpressure;
        int w0;
        cmd = mk(5'h03, 3'd2, 8'd0); dst = 64'h300; src = 64'h77;
        data = 256'h99;
        w0 = wr_cnt_a;
        resp_ready_a = 1'b0;
        valid_a = 1'b1; tick;
        cmd = mk(5'h01, 3'd2, 8'd0); // competing request held during backpressure
        tick;
        for (int c = 0; c < 10; c++) begin
            total++;
            if ({resp_valid_a, ready_a, wr_a, rd_a} !== 4'b1000 ||
                resp_cmd_a !== mk(5'h04, 3'd2, 8'd0) || resp_dst_a !== 64'h77 ||
                resp_src_a !== 64'h300) begin
                bad++; $display("FAIL bp_hold c%0d: got %b %0h %0h %0h want 1000 %0h 77 300", c,
                                {resp_valid_a, ready_a, wr_a, rd_a}, resp_cmd_a, resp_dst_a,
                                resp_src_a, mk(5'h04, 3'd2, 8'd0));
            end
            tick;
        end
        valid_a = 1'b0;
        resp_ready_a = 1'b1;
        tick;
        total++;
        if ({resp_valid_a, ready_a} !== 2'b01 || wr_cnt_a - w0 !== 1) begin
            bad++; $display("FAIL bp_release: got %b n=%0d want 01 n=1", {resp_valid_a, ready_a},
                            wr_cnt_a - w0);
        end
    endtask

    task automatic test_reset_mid;
        cmd = mk(5'h03, 3'd2, 8'd7); dst = 64'h400; src = 64'h1;
        valid_a = 1'b1; tick; valid_a = 1'b0;
        tick; tick;
        total++;
        if (wr_a !== 1'b1) begin
            bad++; $display("FAIL mid_active: got %b want 1", wr_a);
        end
        nreset = 1'b0;
        #1;
        total++;
        if ({wr_a, rd_a, ready_a, resp_valid_a, err_a} !== 5'b0 || addr_a !== '0 ||
            wrdata_a !== '0 || resp_cmd_a !== '0) begin
            bad++; $display("FAIL mid_reset: got %b %0h %0h %0h want 0",
                            {wr_a, rd_a, ready_a, resp_valid_a, err_a}, addr_a, wrdata_a,
                            resp_cmd_a);
        end
        tick; tick;
        nreset = 1'b1;
        tick;
        total++;
        if ({ready_a, wr_a, resp_valid_a} !== 3'b100) begin
            bad++; $display("FAIL mid_recover: got %b want 100", {ready_a, wr_a, resp_valid_a});
        end
        cmd = mk(5'h01, 3'd2, 8'd1); dst = 64'h100; src = 64'h9;
        valid_a = 1'b1; tick; valid_a = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            total++;
            if (rd_a !== 1'b1 || addr_a !== 64'h100 + 64'(4 * (c - 1))) begin
                bad++; $display("FAIL mid_rd c%0d: got %b %0h want 1 %0h", c, rd_a, addr_a,
                                64'h100 + 64'(4 * (c - 1)));
            end
            tick;
        end
        total++;
        if (resp_valid_a !== 1'b0) begin
            bad++; $display("FAIL mid_rd_early: got %b want 0", resp_valid_a);
        end
        tick;
        total++;
        if (resp_valid_a !== 1'b1 || resp_data_a !== 256'h00000022_00000011) begin
            bad++; $display("FAIL mid_rd_resp: got v=%b d=%0h want v=1 d=2200000011",
                            resp_valid_a, resp_data_a);
        end
        tick;
    endtask

    task automatic test_exclusive;
        total++;
        if (both_cnt !== 0) begin
            bad++; $display("FAIL strobe_excl: got %0d want 0", both_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_rdlat3;
        test_posted;
        test_unsup;
        test_backpressure;
        test_reset_mid;
        test_exclusive;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/umi_regif_burst.md
Name: umi_regif_burst

Overview:
- Parametrised successor to the single-word UMI register interface.
- Terminates UMI device requests (read, write, posted write) and splits each burst of LEN+1 words into sequential register-port accesses.
- For reads, packs the returned words into one UMI response.
- Sits between a UMI device port and a synchronous register file or SRAM with configurable read latency.

Parameters:
CW, 32, UMI command width
AW, 64, UMI address width
DW, 256, UMI data width; max burst = DW/RW words
RW, 32, register port width (8/16/32/64, must divide DW)
RDLAT, 1, cycles from reg_read strobe to valid reg_rddata (1..4)

Ports:
clk  input  1  clock
nreset  input  1  asynchronous active-low reset
udev_req_valid  input  1  request valid
udev_req_cmd  input  CW  request command
udev_req_dstaddr  input  AW  request destination address
udev_req_srcaddr  input  AW  request source (return) address
udev_req_data  input  DW  request write data
udev_req_ready  output  1  request accept
udev_resp_valid  output  1  response valid
udev_resp_cmd  output  CW  response command
udev_resp_dstaddr  output  AW  response destination (= request srcaddr)
udev_resp_srcaddr  output  AW  response source (= request dstaddr)
udev_resp_data  output  DW  packed read data
udev_resp_ready  input  1  response accept
reg_addr  output  AW  word address of current access
reg_write  output  1  write strobe
reg_read  output  1  read strobe
reg_wrdata  output  RW  write data
reg_rddata  input  RW  read data, valid RDLAT cycles after reg_read
err_unsup  output  1  one-cycle pulse on a dropped unsupported request

Behaviour:
- Command fields:
  - OPCODE=cmd[4:0]: REQ_READ=0x01, REQ_WRITE=0x03, REQ_POSTED=0x05, RESP_READ=0x02, RESP_WRITE=0x04.
  - SIZE=cmd[7:5]; LEN=cmd[15:8].
- Reset (async, nreset low) forces:
  - state IDLE;
  - udev_req_ready, udev_resp_valid, reg_read, reg_write, err_unsup = 0;
  - all address, data and cmd registers = 0.
  - Any in-flight burst is discarded with no response.
- State IDLE:
  - udev_req_ready=1.
  - Handshake (valid & ready) latches cmd, dstaddr, srcaddr, data; beat counter i=0.
  - Supported = opcode in {01,03,05} AND SIZE==log2(RW/8) AND LEN <= DW/RW-1. Supported -> ACCESS.
  - Otherwise: err_unsup pulses the next cycle, no register access, no response, stay IDLE.
- State ACCESS (udev_req_ready=0), one word per cycle for i=0..LEN:
  - reg_addr = dstaddr + i*(RW/8), modulo 2^AW; wrap is allowed.
  - Writes: reg_write=1, reg_wrdata = req_data[i*RW +: RW].
  - Reads: reg_read=1; word i is captured exactly RDLAT cycles later into resp_data[i*RW +: RW].
  - After i==LEN: write -> RESP; posted -> IDLE; read -> DRAIN.
- State DRAIN: wait until the last word is captured (RDLAT cycles after the final strobe), then RESP.
- State RESP:
  - udev_resp_valid=1. udev_resp_cmd = request cmd with OPCODE replaced by 02 (read) or 04 (write).
  - Address fields swapped; unused resp_data bits are 0; write response data is 0.
  - Outputs are held stable while valid & !ready.
  - On handshake: valid drops the next cycle, state IDLE.
- Latency from request handshake at cycle 0, N=LEN+1:
  - first strobe at cycle 1;
  - write resp_valid at cycle N+1;
  - read resp_valid at cycle N+RDLAT+1.
  - Posted: udev_req_ready=1 again at cycle N+1.
- No request is accepted while a burst or response is pending; exactly one transaction is outstanding.
- reg_read and reg_write are never asserted together.

Test Plan:
- RW=32, REQ_WRITE dst=0x100, LEN=3, data words 0x11,0x22,0x33,0x44 -> reg_write on cycles 1-4 at 0x100/104/108/10C with those words; RESP_WRITE at cycle 5 with dstaddr=req srcaddr and LEN=3.
- Read back the same burst with RDLAT=1 -> resp_valid at cycle 6; resp_data[127:0]=0x00000044_00000033_00000022_00000011; upper bits 0; opcode 0x02.
- RDLAT=3, LEN=0 read at 0x10 -> single reg_read at cycle 1; resp_valid at cycle 5.
- REQ_POSTED LEN=7 (DW=256) -> 8 writes; no udev_resp_valid; udev_req_ready high at cycle 9.
- Unsupported request (SIZE=3 with RW=32, or LEN=8 with DW=256, or opcode 0x07) -> no strobes, no response, err_unsup pulse 1 cycle.
- Hold udev_resp_ready=0 for 10 cycles -> response fields stable, udev_req_ready=0. Assert nreset low mid-ACCESS -> all outputs 0 immediately; next request is served normally.
